// File: rtl/aes_if_pkg.sv
// Shared sizes and FSM state type for the AES word-stream front/back-end.
package aes_if_pkg;

    localparam int unsigned WORDS_PER_BLOCK = 4;
    localparam int unsigned AES_BLK_W       = 128;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

endpackage

// File: rtl/aes_word_unpacker.sv
// Holds one captured ciphertext block and streams it out MSW first as
// 32-bit words with valid/ready; flags the last word and its handshake.
module aes_word_unpacker
    import aes_if_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [AES_BLK_W-1:0] block,
    input  logic                 active,
    input  logic                 out_ready,
    output logic [WORD_W-1:0]    out_data,
    output logic                 out_valid,
    output logic                 out_last,
    output logic                 last_hs
);

    logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] cipher_q;
    logic [1:0]                             out_idx;
    logic                                   hs;

    // Capture the block and rewind to word 0; step one word per handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            cipher_q <= '0;
            out_idx  <= '0;
        end else if (load) begin
            cipher_q <= block;
            out_idx  <= '0;
        end else if (hs) begin
            out_idx <= out_idx + 2'd1;
        end
    end

    // Word k lives in cipher_q[3-k]; outputs are pure functions of registers,
    // so they hold while the consumer stalls.
    always_comb begin
        out_valid = active;
        out_last  = active && (out_idx == 2'd3);
        out_data  = cipher_q[2'd3 - out_idx];
        hs        = active && out_ready;
        last_hs   = hs && (out_idx == 2'd3);
    end

endmodule

// File: rtl/aes_word_stream_if.sv
// Word-stream wrapper around a combinational AES-128 core: packs key and
// plaintext words, holds them for a settle window, captures the cipher and
// hands it to the unpacker for word-wise output.
module aes_word_stream_if
    import aes_if_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned WORD_W        = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_W-1:0]    in_data,
    input  logic                 in_is_key,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [AES_BLK_W-1:0] plain_q,
    output logic [AES_BLK_W-1:0] key_q,
    input  logic [AES_BLK_W-1:0] cipher,
    output logic [WORD_W-1:0]    out_data,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 key_loaded,
    output logic                 busy
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [2:0] FULL_CNT    = 3'(WORDS_PER_BLOCK);
    localparam logic [2:0] KEY_LAST    = 3'(WORDS_PER_BLOCK - 1);

    state_t state, state_next;

    logic [2:0] plain_cnt;
    logic [2:0] key_cnt;
    logic [7:0] settle_cnt;
    logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] plain_w;
    logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] key_w;

    logic block_ready;
    logic in_hs;
    logic capture;
    logic drain_active;
    logic last_hs;

    assign plain_q     = plain_w;
    assign key_q       = key_w;
    assign block_ready = (plain_cnt == FULL_CNT) && key_loaded;
    assign in_hs       = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next state, input acceptance and per-state strobes.
    always_comb begin
        state_next   = state;
        in_ready     = 1'b0;
        busy         = 1'b1;
        capture      = 1'b0;
        drain_active = 1'b0;
        case (state)
            LOAD: begin
                busy     = 1'b0;
                in_ready = !block_ready && (in_is_key || (plain_cnt < FULL_CNT));
                if (block_ready) begin
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    capture    = 1'b1;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                drain_active = 1'b1;
                if (last_hs) begin
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    // Settle window counter: cleared on entry to SETTLE, counts while in it.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= '0;
        end else if (state == LOAD && block_ready) begin
            settle_cnt <= '0;
        end else if (state == SETTLE) begin
            settle_cnt <= settle_cnt + 8'd1;
        end
    end

    // Input packing: word k lands in slot 3-k (MSW first); a new key load
    // drops key_loaded until its fourth word arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            plain_cnt  <= '0;
            key_cnt    <= '0;
            key_loaded <= 1'b0;
            plain_w    <= '0;
            key_w      <= '0;
        end else begin
            if (last_hs) begin
                plain_cnt <= '0;
            end
            if (in_hs) begin
                if (in_is_key) begin
                    key_w[2'd3 - key_cnt[1:0]] <= in_data;
                    if (key_cnt == 3'd0) begin
                        key_loaded <= 1'b0;
                    end
                    if (key_cnt == KEY_LAST) begin
                        key_cnt    <= '0;
                        key_loaded <= 1'b1;
                    end else begin
                        key_cnt <= key_cnt + 3'd1;
                    end
                end else begin
                    plain_w[2'd3 - plain_cnt[1:0]] <= in_data;
                    plain_cnt <= plain_cnt + 3'd1;
                end
            end
        end
    end

    aes_word_unpacker #(
        .WORD_W (WORD_W)
    ) u_unpacker (
        .clk       (clk),
        .rst       (rst),
        .load      (capture),
        .block     (cipher),
        .active    (drain_active),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .last_hs   (last_hs)
    );

endmodule

// File: tb/tb_aes_word_stream_if.sv
// Bench for aes_word_stream_if: a behavioural AES-128 stands in for the
// combinational core; two instances cover the default and minimum settle.
module tb_aes_word_stream_if;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst       [2];
    logic [31:0]  in_data   [2];
    logic         in_is_key [2];
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic [127:0] plain_q   [2];
    logic [127:0] key_q     [2];
    logic [127:0] cipher    [2];
    logic [31:0]  out_data  [2];
    logic         out_last  [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic         key_loaded[2];
    logic         busy      [2];

    int total = 0;
    int bad   = 0;
    int sel   = 0;

    logic [31:0] got_w [4];
    logic [3:0]  got_last;
    int          nwords, stall_bad, inready_bad;
    logic        post_valid, post_busy;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    // ---------------- behavioural AES-128 ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box: field inverse a^254, then the affine map
    function automatic logic [7:0] sb(input logic [7:0] a);
        logic [7:0] p, t;
        p = 8'h01;
        t = a;
        for (int i = 0; i < 7; i++) begin
            t = gm(t, t);
            p = gm(p, t);
        end
        return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes128(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   w [176];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3, rc, tmp;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            w[i] = 8'(key >> (120 - 8 * i));
            s[i] = 8'(pt >> (120 - 8 * i));
        end
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            a0 = w[4*i-4]; a1 = w[4*i-3]; a2 = w[4*i-2]; a3 = w[4*i-1];
            if (i % 4 == 0) begin
                tmp = a0;
                a0  = sb(a1) ^ rc;
                a1  = sb(a2);
                a2  = sb(a3);
                a3  = sb(tmp);
                rc  = xt(rc);
            end
            w[4*i]   = w[4*i-16] ^ a0;
            w[4*i+1] = w[4*i-15] ^ a1;
            w[4*i+2] = w[4*i-14] ^ a2;
            w[4*i+3] = w[4*i-13] ^ a3;
        end
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4*c+row] = sb(s[4*((c+row)%4)+row]);
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
                    s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res = {res[119:0], s[i]};
        return res;
    endfunction

    always_comb begin
        cipher[0] = aes128(key_q[0], plain_q[0]);
        cipher[1] = aes128(key_q[1], plain_q[1]);
    end

    aes_word_stream_if #(.SETTLE_CYCLES(4), .WORD_W(32)) dut (
        .clk(clk), .rst(rst[0]), .in_data(in_data[0]), .in_is_key(in_is_key[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .plain_q(plain_q[0]),
        .key_q(key_q[0]), .cipher(cipher[0]), .out_data(out_data[0]),
        .out_last(out_last[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .key_loaded(key_loaded[0]), .busy(busy[0])
    );

    aes_word_stream_if #(.SETTLE_CYCLES(1), .WORD_W(32)) dut_s1 (
        .clk(clk), .rst(rst[1]), .in_data(in_data[1]), .in_is_key(in_is_key[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .plain_q(plain_q[1]),
        .key_q(key_q[1]), .cipher(cipher[1]), .out_data(out_data[1]),
        .out_last(out_last[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .key_loaded(key_loaded[1]), .busy(busy[1])
    );

    // ---------------- stimulus drivers ----------------
    task automatic do_reset(input int d);
        @(negedge clk);
        rst[d] = 1'b1; in_valid[d] = 1'b0; out_ready[d] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst[d] = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic k);
        int guard;
        @(negedge clk);
        in_data[sel] = d; in_is_key[sel] = k; in_valid[sel] = 1'b1;
        #1;
        guard = 0;
        while (in_ready[sel] !== 1'b1 && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 100) begin
            total++; bad++;
            $display("FAIL send_word_timeout: in_ready=%b required 1", in_ready[sel]);
        end else begin
            @(posedge clk);
        end
        #1 in_valid[sel] = 1'b0;
    endtask

    // Sends optional key words and four plain words; the 4th plain is always last.
    task automatic send_block(input logic [127:0] key, input logic with_key,
                              input logic mix, input logic [127:0] pt);
        int ki, pi;
        ki = with_key ? 0 : 4;
        pi = 0;
        while (pi < 4) begin
            if (ki < 4 && (!mix || pi == 3 || $urandom_range(1, 0) == 1)) begin
                send_word(32'(key >> (96 - 32 * ki)), 1'b1);
                ki++;
            end else begin
                send_word(32'(pt >> (96 - 32 * pi)), 1'b0);
                pi++;
            end
        end
    endtask

    // Cycles from the last acceptance edge to the edge raising out_valid (-1: none).
    task automatic wait_out(output int lat);
        int unsigned c0;
        c0  = cyc;
        lat = -1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (out_valid[sel] === 1'b1) begin
                lat = int'(cyc - c0);
                break;
            end
        end
    endtask

    // Collects four output words, noting stall stability and in_ready leaks.
    task automatic drain_block(input logic rand_ready);
        int          n, guard;
        logic        stalled, hold_l;
        logic [31:0] hold_d;
        n = 0; guard = 0; stalled = 1'b0; hold_d = '0; hold_l = 1'b0;
        stall_bad = 0; inready_bad = 0; got_last = '0;
        for (int k = 0; k < 4; k++) got_w[k] = '0;
        while (n < 4 && guard < 200) begin
            @(negedge clk);
            out_ready[sel] = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
            in_is_key[sel] = 1'($urandom_range(1, 0));
            #1;
            if (in_ready[sel] !== 1'b0) inready_bad++;
            if (stalled && (out_valid[sel] !== 1'b1 || out_data[sel] !== hold_d ||
                            out_last[sel] !== hold_l)) stall_bad++;
            stalled = 1'b0;
            if (out_valid[sel] === 1'b1 && out_ready[sel] === 1'b1) begin
                got_w[n]    = out_data[sel];
                got_last[n] = out_last[sel];
                n++;
            end else if (out_valid[sel] === 1'b1) begin
                stalled = 1'b1;
                hold_d  = out_data[sel];
                hold_l  = out_last[sel];
            end
            guard++;
            @(posedge clk);
        end
        nwords = n;
        #1;
        post_valid     = out_valid[sel];
        post_busy      = busy[sel];
        out_ready[sel] = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            do_reset(d);
            in_is_key[d] = 1'b0;
            #1;
            total++;
            if (out_valid[d] !== 1'b0 || out_last[d] !== 1'b0 || busy[d] !== 1'b0) begin
                bad++;
                $display("FAIL reset_outputs dut%0d: valid=%b last=%b busy=%b, required 0 0 0",
                         d, out_valid[d], out_last[d], busy[d]);
            end
            total++;
            if (key_loaded[d] !== 1'b0 || plain_q[d] !== '0 || key_q[d] !== '0) begin
                bad++;
                $display("FAIL reset_regs dut%0d: key_loaded=%b plain_q=%h key_q=%h, required zero",
                         d, key_loaded[d], plain_q[d], key_q[d]);
            end
            total++;
            if (in_ready[d] !== 1'b1) begin
                bad++;
                $display("FAIL reset_in_ready dut%0d: got %b required 1", d, in_ready[d]);
            end
        end
    endtask

    task automatic test_fips_c1();
        int lat;
        sel = 0;
        send_block(C1_KEY, 1'b1, 1'b0, C1_PT);
        wait_out(lat);
        total++;
        if (lat !== 5) begin
            bad++; $display("FAIL c1_latency: got %0d required 5", lat);
        end
        total++;
        if (key_q[0] !== C1_KEY || plain_q[0] !== C1_PT || busy[0] !== 1'b1) begin
            bad++;
            $display("FAIL c1_held: key_q=%h plain_q=%h busy=%b", key_q[0], plain_q[0], busy[0]);
        end
        drain_block(1'b0);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (got_w[k] !== 32'(C1_CT >> (96 - 32 * k)) || got_last[k] !== (k == 3)) begin
                bad++;
                $display("FAIL c1_word%0d: got %h last=%b required %h last=%b",
                         k, got_w[k], got_last[k], 32'(C1_CT >> (96 - 32 * k)), (k == 3));
            end
        end
        total++;
        if (nwords !== 4 || post_valid !== 1'b0 || post_busy !== 1'b0) begin
            bad++;
            $display("FAIL c1_end: words=%0d valid=%b busy=%b required 4 0 0",
                     nwords, post_valid, post_busy);
        end
    endtask

    task automatic test_key_reuse();
        int           lat;
        logic [127:0] pt, exp;
        sel = 0;
        send_block(B_KEY, 1'b1, 1'b0, B_PT);
        wait_out(lat);
        drain_block(1'b0);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (got_w[k] !== 32'(B_CT >> (96 - 32 * k)) || got_last[k] !== (k == 3)) begin
                bad++;
                $display("FAIL appb_word%0d: got %h required %h",
                         k, got_w[k], 32'(B_CT >> (96 - 32 * k)));
            end
        end
        pt  = {$urandom, $urandom, $urandom, $urandom};
        exp = aes128(B_KEY, pt);
        send_block('0, 1'b0, 1'b0, pt);
        wait_out(lat);
        total++;
        if (lat !== 5 || key_loaded[0] !== 1'b1 || key_q[0] !== B_KEY) begin
            bad++;
            $display("FAIL reuse_state: lat=%0d key_loaded=%b key_q=%h required 5 1 %h",
                     lat, key_loaded[0], key_q[0], B_KEY);
        end
        drain_block(1'b0);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (got_w[k] !== 32'(exp >> (96 - 32 * k))) begin
                bad++;
                $display("FAIL reuse_word%0d: got %h required %h", k, got_w[k], 32'(exp >> (96 - 32 * k)));
            end
        end
    endtask

    task automatic test_plain_before_key();
        int lat;
        sel = 0;
        do_reset(0);
        for (int k = 0; k < 4; k++) send_word(32'(C1_PT >> (96 - 32 * k)), 1'b0);
        @(negedge clk);
        in_data[0] = 32'hdeadbeef; in_is_key[0] = 1'b0; in_valid[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (in_ready[0] !== 1'b0 || busy[0] !== 1'b0 || key_loaded[0] !== 1'b0) begin
                bad++;
                $display("FAIL plain_stall: in_ready=%b busy=%b key_loaded=%b required 0 0 0",
                         in_ready[0], busy[0], key_loaded[0]);
            end
            @(negedge clk);
        end
        in_valid[0] = 1'b0;
        in_is_key[0] = 1'b1;
        #1;
        total++;
        if (in_ready[0] !== 1'b1) begin
            bad++; $display("FAIL key_ready_when_plain_full: got %b required 1", in_ready[0]);
        end
        for (int k = 0; k < 4; k++) send_word(32'(C1_KEY >> (96 - 32 * k)), 1'b1);
        wait_out(lat);
        total++;
        if (lat !== 5) begin
            bad++; $display("FAIL late_key_latency: got %0d required 5", lat);
        end
        drain_block(1'b0);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (got_w[k] !== 32'(C1_CT >> (96 - 32 * k))) begin
                bad++;
                $display("FAIL late_key_word%0d: got %h required %h", k, got_w[k], 32'(C1_CT >> (96 - 32 * k)));
            end
        end
    endtask

    task automatic test_backpressure();
        int           lat;
        logic [127:0] pt, exp;
        sel = 0;
        for (int b = 0; b < 3; b++) begin
            pt  = {$urandom, $urandom, $urandom, $urandom};
            exp = aes128(C1_KEY, pt);
            send_block('0, 1'b0, 1'b0, pt);
            wait_out(lat);
            drain_block(1'b1);
            for (int k = 0; k < 4; k++) begin
                total++;
                if (got_w[k] !== 32'(exp >> (96 - 32 * k)) || got_last[k] !== (k == 3)) begin
                    bad++;
                    $display("FAIL bp_word%0d: got %h last=%b required %h last=%b",
                             k, got_w[k], got_last[k], 32'(exp >> (96 - 32 * k)), (k == 3));
                end
            end
            total++;
            if (stall_bad !== 0 || inready_bad !== 0 || nwords !== 4 || post_valid !== 1'b0) begin
                bad++;
                $display("FAIL bp_handshake: stall_bad=%0d inready_bad=%0d words=%0d valid=%b required 0 0 4 0",
                         stall_bad, inready_bad, nwords, post_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        int           lat;
        logic [127:0] model_key, key, pt, exp;
        logic         new_key;
        sel = 0;
        model_key = C1_KEY;
        for (int b = 0; b < 4; b++) begin
            new_key = (b != 2);
            key     = {$urandom, $urandom, $urandom, $urandom};
            pt      = {$urandom, $urandom, $urandom, $urandom};
            if (new_key) model_key = key;
            exp = aes128(model_key, pt);
            send_block(key, new_key, 1'b1, pt);
            wait_out(lat);
            total++;
            if (lat !== 5) begin
                bad++; $display("FAIL b2b_latency blk%0d: got %0d required 5", b, lat);
            end
            drain_block(1'b1);
            for (int k = 0; k < 4; k++) begin
                total++;
                if (got_w[k] !== 32'(exp >> (96 - 32 * k))) begin
                    bad++;
                    $display("FAIL b2b_word blk%0d w%0d: got %h required %h",
                             b, k, got_w[k], 32'(exp >> (96 - 32 * k)));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        sel = 0;
        send_block(C1_KEY, 1'b1, 1'b0, C1_PT);
        @(posedge clk);
        @(posedge clk);
        #1;
        total++;
        if (busy[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            bad++; $display("FAIL pre_settle_reset: busy=%b valid=%b required 1 0", busy[0], out_valid[0]);
        end
        @(negedge clk);
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (busy[0] !== 1'b0 || out_valid[0] !== 1'b0 || key_loaded[0] !== 1'b0 ||
            plain_q[0] !== '0 || key_q[0] !== '0) begin
            bad++;
            $display("FAIL settle_reset: busy=%b valid=%b key_loaded=%b plain_q=%h key_q=%h required all zero",
                     busy[0], out_valid[0], key_loaded[0], plain_q[0], key_q[0]);
        end
        @(negedge clk);
        rst[0] = 1'b0;
        send_block(C1_KEY, 1'b1, 1'b0, C1_PT);
        wait_out(lat);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            out_ready[0] = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        out_ready[0] = 1'b0;
        #1;
        total++;
        if (out_data[0] !== 32'hd8cdb780 || out_valid[0] !== 1'b1) begin
            bad++;
            $display("FAIL drain_word2: got %h valid=%b required d8cdb780 1", out_data[0], out_valid[0]);
        end
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (busy[0] !== 1'b0 || out_valid[0] !== 1'b0 || out_last[0] !== 1'b0 ||
            key_loaded[0] !== 1'b0 || plain_q[0] !== '0 || key_q[0] !== '0) begin
            bad++;
            $display("FAIL drain_reset: busy=%b valid=%b last=%b key_loaded=%b plain_q=%h key_q=%h required all zero",
                     busy[0], out_valid[0], out_last[0], key_loaded[0], plain_q[0], key_q[0]);
        end
        @(negedge clk);
        rst[0] = 1'b0;
        out_ready[0] = 1'b1;
        send_block(C1_KEY, 1'b1, 1'b1, C1_PT);
        wait_out(lat);
        total++;
        if (lat !== 5) begin
            bad++; $display("FAIL post_reset_latency: got %0d required 5", lat);
        end
        drain_block(1'b0);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (got_w[k] !== 32'(C1_CT >> (96 - 32 * k))) begin
                bad++;
                $display("FAIL post_reset_word%0d: got %h required %h", k, got_w[k], 32'(C1_CT >> (96 - 32 * k)));
            end
        end
    endtask

    task automatic test_settle1();
        int lat;
        sel = 1;
        do_reset(1);
        send_block(C1_KEY, 1'b1, 1'b0, C1_PT);
        wait_out(lat);
        total++;
        if (lat !== 2) begin
            bad++; $display("FAIL s1_latency: got %0d required 2", lat);
        end
        drain_block(1'b1);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (got_w[k] !== 32'(C1_CT >> (96 - 32 * k)) || got_last[k] !== (k == 3)) begin
                bad++;
                $display("FAIL s1_word%0d: got %h last=%b required %h last=%b",
                         k, got_w[k], got_last[k], 32'(C1_CT >> (96 - 32 * k)), (k == 3));
            end
        end
        total++;
        if (nwords !== 4 || post_valid !== 1'b0 || stall_bad !== 0) begin
            bad++;
            $display("FAIL s1_end: words=%0d valid=%b stall_bad=%0d required 4 0 0",
                     nwords, post_valid, stall_bad);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; in_data[d] = '0; in_is_key[d] = 1'b0;
            in_valid[d] = 1'b0; out_ready[d] = 1'b1;
        end
        test_reset();
        test_fips_c1();
        test_key_reuse();
        test_plain_before_key();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_settle1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
